// File: rtl/basket_controller_if.sv
// Terminal-to-basket bus: request pulses, result status and display read port.
// master = terminal/state machine side, slave = basket_controller.
interface basket_controller_if #(
  parameter int TOTAL_W = 16
);
  logic               RSTN_Pulse;
  logic               Enable_Pulse;
  logic               Cancel_Pulse;
  logic [3:0]         ProductID_in;
  logic [3:0]         Quantity_in;
  logic [3:0]         Read_Index;
  logic [3:0]         BasketProductNum;
  logic [TOTAL_W-1:0] TotalPrice;
  logic               Busy;
  logic               Done;
  logic               Error;
  logic [3:0]         Read_ProductID;
  logic [3:0]         Read_Quantity;

  modport master (
    output RSTN_Pulse, Enable_Pulse, Cancel_Pulse,
    output ProductID_in, Quantity_in, Read_Index,
    input  BasketProductNum, TotalPrice,
    input  Busy, Done, Error,
    input  Read_ProductID, Read_Quantity
  );

  modport slave (
    input  RSTN_Pulse, Enable_Pulse, Cancel_Pulse,
    input  ProductID_in, Quantity_in, Read_Index,
    output BasketProductNum, TotalPrice,
    output Busy, Done, Error,
    output Read_ProductID, Read_Quantity
  );
endinterface

// File: rtl/basket_controller.sv
// Shopping basket: up to MAX_ENTRIES {id,qty} slots, running total price.
// Ports: CLOCK_50, RESET_N (async low), bus (slave: pulses in, status/read out).
module basket_controller #(
  parameter int MAX_ENTRIES  = 8,
  parameter int NUM_PRODUCTS = 12,
  parameter int TOTAL_W      = 16
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  basket_controller_if.slave  bus
);

  localparam int IW = $clog2(MAX_ENTRIES);
  localparam int AW = TOTAL_W + 16;
  localparam logic [3:0] MAXC = 4'(MAX_ENTRIES);
  localparam logic [4:0] NPROD = 5'(NUM_PRODUCTS);
  localparam logic [AW-1:0] TMAX =
    {{16{1'b0}}, {TOTAL_W{1'b1}}};

  typedef enum logic [2:0] {
    IDLE, SCAN, COMMIT, SHIFT, TOTAL
  } state_t;

  function automatic logic [7:0] price(
    input logic [3:0] id
  );
    return 8'd10 + 8'd5 * {4'd0, id};
  endfunction

  state_t        state_q;
  logic          add_q;
  logic          found_q;
  logic [3:0]    id_q;
  logic [3:0]    qty_q;
  logic [3:0]    idx_q;
  logic [3:0]    k_q;
  logic [3:0]    count_q;
  logic [3:0]    slot_id_q  [MAX_ENTRIES];
  logic [3:0]    slot_qty_q [MAX_ENTRIES];
  logic [AW-1:0] acc_q;
  logic [TOTAL_W-1:0] total_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [IW-1:0] idx_s;
  logic [IW-1:0] k_s;
  logic [IW-1:0] k1_s;
  logic [IW-1:0] cnt_s;
  logic [IW-1:0] rd_s;
  logic          scan_end;
  logic          scan_hit;
  logic [4:0]    sum5;
  logic [3:0]    sat_qty;
  logic [11:0]   term;
  logic          rd_hit;

  assign idx_s = idx_q[IW-1:0];
  assign k_s   = k_q[IW-1:0];
  assign k1_s  = IW'(k_q + 4'd1);
  assign cnt_s = count_q[IW-1:0];
  assign rd_s  = bus.Read_Index[IW-1:0];

  // End-of-list is tested first so slot contents past count never match.
  assign scan_end = (idx_q == count_q);
  assign scan_hit = !scan_end && (slot_id_q[idx_s] == id_q);

  assign sum5    = {1'b0, slot_qty_q[k_s]} + {1'b0, qty_q};
  assign sat_qty = sum5[4] ? 4'hF : sum5[3:0];

  assign term = {8'd0, slot_qty_q[idx_s]} *
                {4'd0, price(slot_id_q[idx_s])};

  assign rd_hit = (bus.Read_Index < count_q);

  assign bus.Read_ProductID   = rd_hit ? slot_id_q[rd_s]  : 4'hF;
  assign bus.Read_Quantity    = rd_hit ? slot_qty_q[rd_s] : 4'h0;
  assign bus.BasketProductNum = count_q;
  assign bus.TotalPrice       = total_q;
  assign bus.Busy             = busy_q;
  assign bus.Done             = done_q;
  assign bus.Error            = err_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      add_q   <= 1'b0;
      found_q <= 1'b0;
      id_q    <= 4'h0;
      qty_q   <= 4'h0;
      idx_q   <= 4'h0;
      k_q     <= 4'h0;
      count_q <= 4'h0;
      acc_q   <= '0;
      total_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        slot_id_q[i]  <= 4'hF;
        slot_qty_q[i] <= 4'h0;
      end
    end else if (!bus.RSTN_Pulse) begin
      state_q <= IDLE;
      add_q   <= 1'b0;
      found_q <= 1'b0;
      id_q    <= 4'h0;
      qty_q   <= 4'h0;
      idx_q   <= 4'h0;
      k_q     <= 4'h0;
      count_q <= 4'h0;
      acc_q   <= '0;
      total_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        slot_id_q[i]  <= 4'hF;
        slot_qty_q[i] <= 4'h0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Cancel outranks a simultaneous enable.
          if (bus.Cancel_Pulse) begin
            add_q <= 1'b0;
            id_q  <= bus.ProductID_in;
            if (count_q == 4'd0) begin
              err_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              idx_q   <= 4'd0;
              state_q <= SCAN;
            end
          end else if (bus.Enable_Pulse) begin
            add_q <= 1'b1;
            id_q  <= bus.ProductID_in;
            qty_q <= bus.Quantity_in;
            if (bus.Quantity_in == 4'd0 ||
                {1'b0, bus.ProductID_in} >= NPROD) begin
              err_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              idx_q   <= 4'd0;
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_end) begin
            found_q <= 1'b0;
            state_q <= COMMIT;
          end else if (scan_hit) begin
            found_q <= 1'b1;
            k_q     <= idx_q;
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        COMMIT: begin
          if (add_q) begin
            if (found_q) begin
              slot_qty_q[k_s] <= sat_qty;
              idx_q   <= 4'd0;
              acc_q   <= '0;
              state_q <= TOTAL;
            end else if (count_q < MAXC) begin
              slot_id_q[cnt_s]  <= id_q;
              slot_qty_q[cnt_s] <= qty_q;
              count_q <= count_q + 4'd1;
              idx_q   <= 4'd0;
              acc_q   <= '0;
              state_q <= TOTAL;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (found_q) begin
            state_q <= SHIFT;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          // Close the gap one slot per cycle; the tail slot is cleared last.
          if (k_q == count_q - 4'd1) begin
            slot_id_q[k_s]  <= 4'hF;
            slot_qty_q[k_s] <= 4'h0;
            count_q <= count_q - 4'd1;
            idx_q   <= 4'd0;
            acc_q   <= '0;
            state_q <= TOTAL;
          end else begin
            slot_id_q[k_s]  <= slot_id_q[k1_s];
            slot_qty_q[k_s] <= slot_qty_q[k1_s];
            k_q <= k_q + 4'd1;
          end
        end
        TOTAL: begin
          if (scan_end) begin
            total_q <= (acc_q > TMAX) ? {TOTAL_W{1'b1}}
                                      : acc_q[TOTAL_W-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_q + {{(AW-12){1'b0}}, term};
            idx_q <= idx_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_basket_controller.sv
// Self-checking bench for basket_controller against a queue-based basket model.
// Directed test-plan steps followed by randomized add/cancel traffic.
module tb_basket_controller;

  localparam int MAXE = 8;
  localparam int NPROD = 12;
  localparam int WIN = 3 * MAXE + 8;
  localparam int DONE_LAT = 3 * MAXE + 4;
  localparam int ERR_LAT = MAXE + 3;

  typedef struct {
    logic [3:0] id;
    logic [3:0] qty;
  } ent_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   dn, er, fd, fe;
  ent_t bq[$];

  basket_controller_if #(.TOTAL_W(16)) bif ();

  basket_controller #(
    .MAX_ENTRIES(MAXE),
    .NUM_PRODUCTS(NPROD),
    .TOTAL_W(16)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_total();
    int s = 0;
    foreach (bq[i]) s += int'(bq[i].qty) * (10 + 5 * int'(bq[i].id));
    if (s > 65535) s = 65535;
    return s;
  endfunction

  function automatic int find(input logic [3:0] id);
    foreach (bq[i]) if (bq[i].id == id) return i;
    return -1;
  endfunction

  // Basket rules applied to the queue; returns expected Done/Error pulses.
  task automatic model_apply(input bit en, input bit can,
                             input logic [3:0] id, input logic [3:0] q,
                             output int ed, output int ee);
    int p;
    ent_t e;
    ed = 0;
    ee = 0;
    if (can) begin
      p = find(id);
      if (p < 0) ee = 1;
      else begin
        bq.delete(p);
        ed = 1;
      end
    end else if (en) begin
      p = find(id);
      if (q == 0 || int'(id) >= NPROD) ee = 1;
      else if (p >= 0) begin
        bq[p].qty = (int'(bq[p].qty) + int'(q) > 15) ? 4'hF
                    : bq[p].qty + q;
        ed = 1;
      end else if (bq.size() < MAXE) begin
        e.id = id;
        e.qty = q;
        bq.push_back(e);
        ed = 1;
      end else ee = 1;
    end
  endtask

  task automatic drive(input bit en, input bit can,
                       input logic [3:0] id, input logic [3:0] q);
    bif.Enable_Pulse = en;
    bif.Cancel_Pulse = can;
    bif.ProductID_in = id;
    bif.Quantity_in  = q;
  endtask

  task automatic watch(input int win, input int start);
    for (int c = start; c < start + win; c++) begin
      if (bif.Done) begin
        dn++;
        if (fd == 0) fd = c;
      end
      if (bif.Error) begin
        er++;
        if (fe == 0) fe = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] ex;
    chk({tag, ".count"}, 32'(bif.BasketProductNum), 32'(bq.size()));
    chk({tag, ".total"}, 32'(bif.TotalPrice), 32'(model_total()));
    chk({tag, ".busy"}, 32'(bif.Busy), 32'd0);
    for (int i = 0; i <= MAXE + 1; i++) begin
      int ri;
      ri = (i == MAXE + 1) ? 15 : i;
      bif.Read_Index = 4'(ri);
      #1;
      ex = (ri < bq.size()) ? {bq[ri].id, bq[ri].qty} : 8'hF0;
      chk($sformatf("%s.rd%0d", tag, ri),
          32'({bif.Read_ProductID, bif.Read_Quantity}), 32'(ex));
    end
  endtask

  task automatic do_op(input string tag, input bit en, input bit can,
                       input logic [3:0] id, input logic [3:0] q);
    int ed, ee;
    model_apply(en, can, id, q, ed, ee);
    @(negedge clk);
    drive(en, can, id, q);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    dn = 0; er = 0; fd = 0; fe = 0;
    watch(WIN, 1);
    chk({tag, ".done"}, 32'(dn), 32'(ed));
    chk({tag, ".err"}, 32'(er), 32'(ee));
    if (ed != 0) chk({tag, ".dlat"}, 32'(fd <= DONE_LAT), 32'd1);
    if (ee != 0) chk({tag, ".elat"}, 32'(fe <= ERR_LAT), 32'd1);
    check_state(tag);
  endtask

  task automatic clear_basket();
    @(negedge clk);
    bif.RSTN_Pulse = 1'b0;
    @(negedge clk);
    bif.RSTN_Pulse = 1'b1;
    bq.delete();
  endtask

  initial begin
    int ed, ee, r;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bif.RSTN_Pulse = 1'b1;
    bif.Read_Index = 4'h0;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.done", 32'(bif.Done), 32'd0);
    chk("rst.error", 32'(bif.Error), 32'd0);
    check_state("rst");

    do_op("add2x3", 1, 0, 4'd2, 4'd3);
    do_op("add2x14", 1, 0, 4'd2, 4'd14);

    clear_basket();
    check_state("clr1");
    do_op("a0", 1, 0, 4'd0, 4'd1);
    do_op("a1", 1, 0, 4'd1, 4'd1);
    do_op("a2", 1, 0, 4'd2, 4'd1);
    do_op("c0", 0, 1, 4'd0, 4'd0);
    do_op("c_absent", 0, 1, 4'd9, 4'd0);
    do_op("a_q0", 1, 0, 4'd3, 4'd0);
    do_op("a_id12", 1, 0, 4'd12, 4'd4);
    do_op("c_last", 0, 1, 4'd2, 4'd0);

    clear_basket();
    do_op("c_empty", 0, 1, 4'd1, 4'd0);
    for (int i = 0; i < MAXE; i++)
      do_op($sformatf("fill%0d", i), 1, 0, 4'(i), 4'(i + 1));
    do_op("a_full", 1, 0, 4'd8, 4'd2);
    do_op("a_full_hit", 1, 0, 4'd7, 4'd9);
    do_op("c_first", 0, 1, 4'd0, 4'd0);

    // Abort mid-SHIFT: cancel slot 0 of a 5-entry basket.
    clear_basket();
    for (int i = 0; i < 5; i++)
      do_op($sformatf("pre%0d", i), 1, 0, 4'(i), 4'd2);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort.busy_pre", 32'(bif.Busy), 32'd1);
    bif.RSTN_Pulse = 1'b0;
    @(negedge clk);
    bif.RSTN_Pulse = 1'b1;
    bq.delete();
    chk("abort.done_now", 32'(bif.Done), 32'd0);
    dn = 0; er = 0; fd = 0; fe = 0;
    watch(WIN, 1);
    chk("abort.done", 32'(dn), 32'd0);
    chk("abort.err", 32'(er), 32'd0);
    check_state("abort");

    // Enable while busy is dropped: exactly one Done.
    model_apply(1, 0, 4'd5, 4'd1, ed, ee);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd5, 4'd1);
    @(negedge clk);
    chk("busy.busy", 32'(bif.Busy), 32'd1);
    drive(1'b1, 1'b0, 4'd6, 4'd2);
    dn = 0; er = 0; fd = 0; fe = 0;
    watch(1, 1);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    watch(WIN, 2);
    chk("busy.done", 32'(dn), 32'd1);
    chk("busy.err", 32'(er), 32'd0);
    check_state("busy");

    // Cancel and enable together: cancel wins.
    do_op("both", 1, 1, 4'd5, 4'd1);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)
        do_op($sformatf("rnd%0d", n), 1, 0,
              4'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
      else if (r < 9)
        do_op($sformatf("rnd%0d", n), 0, 1,
              4'($urandom_range(0, 11)), 4'd0);
      else
        do_op($sformatf("rnd%0d", n), 1, 1,
              4'($urandom_range(0, 11)), 4'($urandom_range(1, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
